mbf_prog: RTL and testbench

- Parametrised, run-time-programmable two-bank FIR filter; successor to the fixed-coefficient 12-tap MBF.
- One input sample stream feeds two independent coefficient banks (X bank, Y bank). Each bank produces a rounded, saturated filter output.
- Adds coefficient programming, signed arithmetic, explicit valid tracking through the pipeline, saturation flags and a synchronous clear.
- Sits between the sample source and the downstream X/Y consumers.

---
 rtl/mbf_prog.sv | 148 ++++++++++++++
 tb/tb_mbf_prog.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbf_prog.sv
// Run-time programmable two-bank FIR filter: one sample stream, X and Y coefficient
// banks, 3-cycle latency from the accepting edge, rounded and saturated outputs.
module mbf_prog #(
    parameter int NUM_TAPS = 12,
    parameter int DATA_W   = 13,
    parameter int COEF_W   = 5,
    parameter int SHIFT    = 9,
    parameter int ADDR_W   = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CLEAR,
    input  logic                     IN_VALID,
    input  logic signed [DATA_W-1:0] IN_DATA,
    input  logic                     COEF_WE,
    input  logic                     COEF_BANK,
    input  logic        [ADDR_W-1:0] COEF_ADDR,
    input  logic signed [COEF_W-1:0] COEF_DATA,
    output logic signed [DATA_W-1:0] X_DATA,
    output logic signed [DATA_W-1:0] Y_DATA,
    output logic                     OUT_VALID,
    output logic                     X_SAT,
    output logic                     Y_SAT
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] HALF    = RND_W'(1) << (SHIFT - 1);
    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [DATA_W-1:0] x_dly  [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_x [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_y [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_x [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_y [NUM_TAPS];
    logic signed [ACC_W-1:0]  sum_x, sum_y;
    logic signed [ACC_W-1:0]  acc_x, acc_y;
    logic                     dly_valid, prod_valid, acc_valid;

    // Returns {saturated, value}; round half toward +infinity, then clamp.
    function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [RND_W-1:0] r;
        r = $signed({acc[ACC_W-1], acc});
        r = (r + HALF) >>> SHIFT;
        if (r > OUT_MAX)
            round_sat = {1'b1, OUT_MAX[DATA_W-1:0]};
        else if (r < OUT_MIN)
            round_sat = {1'b1, OUT_MIN[DATA_W-1:0]};
        else
            round_sat = {1'b0, r[DATA_W-1:0]};
    endfunction

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_TAPS; i++) x_dly[i] <= '0;
            dly_valid <= 1'b0;
        end else if (CLEAR) begin
            for (int i = 0; i < NUM_TAPS; i++) x_dly[i] <= '0;
            dly_valid <= 1'b0;
        end else begin
            dly_valid <= IN_VALID;
            if (IN_VALID) begin
                x_dly[0] <= IN_DATA;
                for (int i = 1; i < NUM_TAPS; i++) x_dly[i] <= x_dly[i-1];
            end
        end
    end

    // NOTE: the coefficient banks are reset because a reset filter must output zero
    // until reprogrammed; the array is small enough to live in flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef_x[i] <= '0;
                coef_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (COEF_WE && COEF_ADDR == ADDR_W'(i)) begin
                    if (COEF_BANK) coef_y[i] <= COEF_DATA;
                    else           coef_x[i] <= COEF_DATA;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                prod_x[i] <= '0;
                prod_y[i] <= '0;
            end
            prod_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                prod_x[i] <= PROD_W'(x_dly[i]) * PROD_W'(coef_x[i]);
                prod_y[i] <= PROD_W'(x_dly[i]) * PROD_W'(coef_y[i]);
            end
            prod_valid <= dly_valid && !CLEAR;
        end
    end

    // NOTE: the sums get a default before the loop so no latch is inferred.
    always_comb begin
        sum_x = '0;
        sum_y = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            sum_x = sum_x + ACC_W'(prod_x[i]);
            sum_y = sum_y + ACC_W'(prod_y[i]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_x     <= '0;
            acc_y     <= '0;
            acc_valid <= 1'b0;
        end else begin
            acc_x     <= sum_x;
            acc_y     <= sum_y;
            acc_valid <= prod_valid && !CLEAR;
        end
    end

    // CLEAR also drops a result that would register on the clearing edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            X_DATA    <= '0;
            Y_DATA    <= '0;
            X_SAT     <= 1'b0;
            Y_SAT     <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (CLEAR || !acc_valid) begin
            X_SAT     <= 1'b0;
            Y_SAT     <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            {X_SAT, X_DATA} <= round_sat(acc_x);
            {Y_SAT, Y_DATA} <= round_sat(acc_y);
            OUT_VALID       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mbf_prog.sv
// Self-checking bench for mbf_prog: a SHIFT=9 and a SHIFT=4 instance share one stimulus
// stream and are compared every cycle against a sum-of-products reference model.
module tb_mbf_prog;

    localparam int NUM_TAPS = 12;
    localparam int DATA_W   = 13;
    localparam int COEF_W   = 5;
    localparam int ADDR_W   = 4;
    localparam int OUT_MAX  = 4095;
    localparam int OUT_MIN  = -4096;

    logic clk = 1'b0, reset = 1'b0, clear = 1'b0, in_valid = 1'b0;
    logic coef_we = 1'b0, coef_bank = 1'b0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic        [ADDR_W-1:0] coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic signed [DATA_W-1:0] x9, y9, x4, y4;
    logic ov9, ov4, xs9, ys9, xs4, ys4;

    mbf_prog dut9 (
        .CLK(clk), .RESET(reset), .CLEAR(clear), .IN_VALID(in_valid), .IN_DATA(in_data),
        .COEF_WE(coef_we), .COEF_BANK(coef_bank), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .X_DATA(x9), .Y_DATA(y9), .OUT_VALID(ov9), .X_SAT(xs9), .Y_SAT(ys9)
    );

    mbf_prog #(.SHIFT(4)) dut4 (
        .CLK(clk), .RESET(reset), .CLEAR(clear), .IN_VALID(in_valid), .IN_DATA(in_data),
        .COEF_WE(coef_we), .COEF_BANK(coef_bank), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .X_DATA(x4), .Y_DATA(y4), .OUT_VALID(ov4), .X_SAT(xs4), .Y_SAT(ys4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x9; int y9; int x4; int y4;
        bit xs9; bit ys9; bit xs4; bit ys4;
    } exp_t;

    typedef struct { int din; int exp9; int exp4; } rvec_t;

    int    checks = 0, errors = 0, cycle = 0;
    int    m_c [2][NUM_TAPS];
    int    hist [NUM_TAPS];
    exp_t  exp_q [$];
    int    last_x9 = 0, last_y9 = 0, last_x4 = 0, last_y4 = 0;
    int    imp [NUM_TAPS];
    int    mid_exp [4];
    rvec_t rv [8];
    int    pulses [$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp_v, cycle);
        end
    endtask

    function automatic int round_sat(input longint acc, input int sh, output bit sat);
        longint r;
        r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
        sat = 1'b1;
        if (r > OUT_MAX) return OUT_MAX;
        if (r < OUT_MIN) return OUT_MIN;
        sat = 1'b0;
        return int'(r);
    endfunction

    task automatic model_flush();
        foreach (hist[i]) hist[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        exp_t   e;
        longint ax, ay;
        if (reset) return;
        if (coef_we && int'(coef_addr) < NUM_TAPS) m_c[coef_bank][coef_addr] = coef_data;
        if (clear) begin
            model_flush();
        end else if (in_valid) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = in_data;
            ax = 0;
            ay = 0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                ax += longint'(m_c[0][i]) * hist[i];
                ay += longint'(m_c[1][i]) * hist[i];
            end
            e.due = cycle + 3;
            e.x9  = round_sat(ax, 9, e.xs9);
            e.y9  = round_sat(ay, 9, e.ys9);
            e.x4  = round_sat(ax, 4, e.xs4);
            e.y4  = round_sat(ay, 4, e.ys4);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   ev;
        ev   = 1'b0;
        e.x9 = last_x9; e.y9 = last_y9; e.x4 = last_x4; e.y4 = last_y4;
        e.xs9 = 1'b0; e.ys9 = 1'b0; e.xs4 = 1'b0; e.ys4 = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            e  = exp_q.pop_front();
            ev = 1'b1;
        end
        check("out_valid",    ov9, ev);
        check("out_valid_s4", ov4, ev);
        check("x_data",    x9, e.x9);
        check("y_data",    y9, e.y9);
        check("x_data_s4", x4, e.x4);
        check("y_data_s4", y4, e.y4);
        check("x_sat",    xs9, e.xs9);
        check("y_sat",    ys9, e.ys9);
        check("x_sat_s4", xs4, e.xs4);
        check("y_sat_s4", ys4, e.ys4);
        last_x9 = e.x9; last_y9 = e.y9; last_x4 = e.x4; last_y4 = e.y4;
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int d);
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wcoef(input int bank, input int addr, input int data);
        coef_we   = 1'b1;
        coef_bank = 1'(bank);
        coef_addr = ADDR_W'(addr);
        coef_data = COEF_W'(data);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        model_flush();
        foreach (m_c[b, i]) m_c[b][i] = 0;
        last_x9 = 0; last_y9 = 0; last_x4 = 0; last_y4 = 0;
        #1;
        check("rst_valid", ov9, 0);  check("rst_valid_s4", ov4, 0);
        check("rst_x", x9, 0);       check("rst_y", y9, 0);
        check("rst_x_s4", x4, 0);    check("rst_y_s4", y4, 0);
        check("rst_xsat", xs9, 0);   check("rst_ysat", ys9, 0);
        check("rst_xsat_s4", xs4, 0); check("rst_ysat_s4", ys4, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        imp     = '{14, 4, 3, 1, -16, 14, -4, -16, -1, -4, -1, -15};
        mid_exp = '{1, 2, 2, 2};
        rv = '{'{256, 1, 16}, '{-256, 0, -16}, '{255, 0, 16}, '{-257, -1, -16},
               '{511, 1, 32}, '{4095, 8, 256}, '{-4096, -8, -256}, '{0, 0, 0}};

        #2;
        async_reset();

        // Impulse: X output replays the coefficient list, Y stays zero.
        for (int i = 0; i < NUM_TAPS; i++) wcoef(0, i, imp[i]);
        for (int j = 0; j < 15; j++) begin
            in_valid = (j < 12);
            in_data  = DATA_W'((j == 0) ? 512 : 0);
            tick();
            if (j >= 3) begin
                check("imp_valid", ov9, 1);
                check("imp_x", x9, imp[j-3]);
                check("imp_y", y9, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        check("imp_end_valid", ov9, 0);

        // Rounding table with a single unit tap.
        for (int i = 0; i < NUM_TAPS; i++) wcoef(0, i, (i == 0) ? 1 : 0);
        for (int k = 0; k < 8; k++) begin
            send(rv[k].din);
            idle(3);
            check("rnd_valid", ov9, 1);
            check("rnd_x", x9, rv[k].exp9);
            check("rnd_x_s4", x4, rv[k].exp4);
            check("rnd_sat_s4", xs4, 0);
        end

        // Saturation in both directions on the SHIFT=4 instance.
        for (int i = 0; i < NUM_TAPS; i++) wcoef(0, i, 15);
        do_clear();
        repeat (14) send(4095);
        check("sat_hi_x", x4, OUT_MAX);
        check("sat_hi_flag", xs4, 1);
        repeat (14) send(-4096);
        check("sat_lo_x", x4, OUT_MIN);
        check("sat_lo_flag", xs4, 1);
        idle(3);

        // Gapped input: two idle cycles between samples.
        for (int i = 0; i < NUM_TAPS; i++) wcoef(0, i, imp[i]);
        for (int i = 0; i < NUM_TAPS; i++) wcoef(1, i, 3 - i);
        do_clear();
        for (int t = 0; t < 27; t++) begin
            in_valid = (t % 3 == 0) && (t < 24);
            in_data  = DATA_W'($urandom);
            tick();
            if (ov9) pulses.push_back(cycle);
        end
        in_valid = 1'b0;
        check("gap_pulses", pulses.size(), 8);
        for (int k = 1; k < pulses.size(); k++) check("gap_spacing", pulses[k] - pulses[k-1], 3);

        // Mid-stream coefficient change and an out-of-range write.
        for (int i = 0; i < NUM_TAPS; i++) wcoef(0, i, (i == 0) ? 1 : 0);
        do_clear();
        for (int j = 0; j < 7; j++) begin
            in_valid  = (j < 4);
            in_data   = DATA_W'(512);
            coef_we   = (j == 1) || (j == 2);
            coef_bank = 1'b0;
            coef_addr = ADDR_W'((j == 1) ? 0 : 13);
            coef_data = COEF_W'((j == 1) ? 2 : 7);
            tick();
            coef_we = 1'b0;
            if (j >= 3) begin
                check("mid_valid", ov9, 1);
                check("mid_x", x9, mid_exp[j-3]);
            end
        end
        in_valid = 1'b0;

        // CLEAR with a sample and a coefficient write on the same edge.
        send(512);
        send(512);
        clear = 1'b1; in_valid = 1'b1; in_data = DATA_W'(512);
        coef_we = 1'b1; coef_bank = 1'b0; coef_addr = ADDR_W'(1); coef_data = COEF_W'(3);
        tick();
        clear = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("clr_no_valid", ov9, 0);
            check("clr_hold_x", x9, 2);
        end
        send(512);
        send(0);
        idle(2);
        check("clr_first_valid", ov9, 1);
        check("clr_first_x", x9, 2);
        tick();
        check("clr_second_x", x9, 3);
        idle(2);

        // Randomized traffic against the model.
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_TAPS; i++) wcoef(b, i, $urandom);
        repeat (400) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = DATA_W'($urandom);
            clear     = ($urandom % 40) == 0;
            coef_we   = ($urandom % 8) == 0;
            coef_bank = 1'($urandom);
            coef_addr = ADDR_W'($urandom);
            coef_data = COEF_W'($urandom);
            tick();
        end
        in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
        idle(3);

        // Asynchronous reset mid-burst, then zero output until reprogrammed.
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_TAPS; i++) wcoef(b, i, $urandom);
        repeat (8) send($urandom);
        async_reset();
        for (int t = 0; t < 9; t++) begin
            in_valid = (t < 6);
            in_data  = DATA_W'($urandom | 1);
            tick();
            if (t >= 3) begin
                check("post_rst_valid", ov9, 1);
                check("post_rst_x", x9, 0);
                check("post_rst_y", y9, 0);
                check("post_rst_x_s4", x4, 0);
            end
        end
        in_valid = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
